// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: detection inputs from ID/EX/MEM and stage enable/flush controls.
// The controller binds the slave modport and the pipeline binds the master modport.
interface hazard_ctrl_if;
  logic [4:0] IF_ID_RegisterRs_i;
  logic [4:0] IF_ID_RegisterRt_i;
  logic       ID_EX_MemRead_i;
  logic [4:0] ID_EX_RegisterRt_i;
  logic       Branch_taken_i;
  logic       Mem_req_i;
  logic       Mem_ready_i;
  logic       PC_Write_o;
  logic       IF_ID_Write_o;
  logic       IF_ID_Flush_o;
  logic       ID_EX_Flush_o;
  logic       EX_MEM_Flush_o;
  logic       Pipe_Stall_o;
  logic       Mem_timeout_o;
  logic [1:0] State_o;

  modport master (
    output IF_ID_RegisterRs_i, IF_ID_RegisterRt_i, ID_EX_MemRead_i, ID_EX_RegisterRt_i,
           Branch_taken_i, Mem_req_i, Mem_ready_i,
    input  PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Flush_o,
           Pipe_Stall_o, Mem_timeout_o, State_o
  );

  modport slave (
    input  IF_ID_RegisterRs_i, IF_ID_RegisterRt_i, ID_EX_MemRead_i, ID_EX_RegisterRt_i,
           Branch_taken_i, Mem_req_i, Mem_ready_i,
    output PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Flush_o,
           Pipe_Stall_o, Mem_timeout_o, State_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS hazard controller: load-use stalls, branch flushes and memory-wait freezes.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush/freeze cycle counters.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] Stall_cnt_o,
  output logic [31:0] Flush_cnt_o,
  output logic [31:0] Wait_cnt_o,
`endif
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    StRun       = 2'd0,
    StLoadStall = 2'd1,
    StMemWait   = 2'd2
  } state_e;

  localparam logic [3:0] StallInit  = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  state_e     ret_q, ret_d;
  logic [3:0] stall_cnt_q, stall_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  logic lu, mw, br, rdy;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, pipe_stall;

  assign lu  = hz.ID_EX_MemRead_i && (hz.ID_EX_RegisterRt_i != 5'd0) &&
               ((hz.ID_EX_RegisterRt_i == hz.IF_ID_RegisterRs_i) ||
                (hz.ID_EX_RegisterRt_i == hz.IF_ID_RegisterRt_i));
  assign mw  = hz.Mem_req_i && !hz.Mem_ready_i;
  assign br  = hz.Branch_taken_i;
  assign rdy = hz.Mem_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      ret_q       <= StRun;
      stall_cnt_q <= 4'd0;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    stall_cnt_d = stall_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    case (state_q)
      StRun: begin
        if (mw) begin
          ret_d      = StRun;
          wait_cnt_d = 8'd1;
          state_d    = StMemWait;
        end else if (!br && lu && (LOAD_STALL_CYCLES != 1)) begin
          stall_cnt_d = StallInit;
          state_d     = StLoadStall;
        end
      end
      StLoadStall: begin
        if (mw) begin
          // Stall counter is held so the remaining bubbles resume after the freeze.
          ret_d      = StLoadStall;
          wait_cnt_d = 8'd1;
          state_d    = StMemWait;
        end else if (br) begin
          stall_cnt_d = 4'd0;
          state_d     = StRun;
        end else begin
          stall_cnt_d = stall_cnt_q - 4'd1;
          if (stall_cnt_q == 4'd1) state_d = StRun;
        end
      end
      StMemWait: begin
        if (rdy) begin
          state_d    = ret_q;
          wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = StRun;
    endcase
    // wait_cnt_d is zero outside a wait, and TimeoutVal is never zero.
    if (wait_cnt_d == TimeoutVal) timeout_d = 1'b1;
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pipe_stall   = 1'b0;
    if (rst_i) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      case (state_q)
        StRun, StLoadStall: begin
          if (mw) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_stall  = 1'b1;
          end else if (br) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
          end else if (lu || (state_q == StLoadStall)) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        StMemWait: begin
          if (!rdy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_stall  = 1'b1;
          end else if (ret_q == StLoadStall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hz.PC_Write_o     = pc_write;
  assign hz.IF_ID_Write_o  = if_id_write;
  assign hz.IF_ID_Flush_o  = if_id_flush;
  assign hz.ID_EX_Flush_o  = id_ex_flush;
  assign hz.EX_MEM_Flush_o = ex_mem_flush;
  assign hz.Pipe_Stall_o   = pipe_stall;
  assign hz.Mem_timeout_o  = timeout_q;
  assign hz.State_o        = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_perf_q, flush_perf_q, wait_perf_q;
  logic        stall_ev, flush_ev, freeze_ev;

  // A flush also raises ID_EX_Flush, so stall cycles exclude flush cycles.
  assign stall_ev  = !rst_i && id_ex_flush && !ex_mem_flush;
  assign flush_ev  = !rst_i && ex_mem_flush;
  assign freeze_ev = pipe_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_perf_q <= 32'd0;
      flush_perf_q <= 32'd0;
      wait_perf_q  <= 32'd0;
    end else begin
      if (stall_ev && (stall_perf_q != 32'hFFFF_FFFF)) stall_perf_q <= stall_perf_q + 32'd1;
      if (flush_ev && (flush_perf_q != 32'hFFFF_FFFF)) flush_perf_q <= flush_perf_q + 32'd1;
      if (freeze_ev && (wait_perf_q != 32'hFFFF_FFFF)) wait_perf_q <= wait_perf_q + 32'd1;
    end
  end

  assign Stall_cnt_o = stall_perf_q;
  assign Flush_cnt_o = flush_perf_q;
  assign Wait_cnt_o  = wait_perf_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS pipeline. It detects load-use hazards, stalls for a configurable number of cycles and inserts ID/EX bubbles. It flushes wrong-path instructions on a taken branch resolved in MEM, and freezes the whole pipeline while a multi-cycle data memory access is outstanding. It sits beside the forwarding logic and drives the write-enable and flush controls of PC, IF/ID, ID/EX and EX/MEM.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard (1..15).
- MEM_TIMEOUT, 255: MEM_WAIT cycles before Mem_timeout_o is raised (1..255).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- IF_ID_RegisterRs_i  in  5  Rs of instruction in ID.
- IF_ID_RegisterRt_i  in  5  Rt of instruction in ID.
- ID_EX_MemRead_i  in  1  instruction in EX is a load.
- ID_EX_RegisterRt_i  in  5  destination of the load in EX.
- Branch_taken_i  in  1  taken branch resolved in MEM this cycle.
- Mem_req_i  in  1  MEM-stage instruction accesses data memory.
- Mem_ready_i  in  1  data memory completes the access this cycle.
- PC_Write_o  out  1  PC update enable.
- IF_ID_Write_o  out  1  IF/ID register enable.
- IF_ID_Flush_o  out  1  zero IF/ID on next edge.
- ID_EX_Flush_o  out  1  load bubble into ID/EX on next edge.
- EX_MEM_Flush_o  out  1  zero EX/MEM control on next edge.
- Pipe_Stall_o  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- Mem_timeout_o  out  1  sticky timeout flag.
- State_o  out  2  current state: RUN=0, LOAD_STALL=1, MEM_WAIT=2.

## Operation
- Registered state: FSM state, return-state register, stall counter (4 bits), wait counter (8 bits), timeout flag. All control outputs are Mealy: decoded from state and current inputs.
- Load-use hazard (LU): ID_EX_MemRead_i & ID_EX_RegisterRt_i!=0 & (ID_EX_RegisterRt_i==IF_ID_RegisterRs_i | ID_EX_RegisterRt_i==IF_ID_RegisterRt_i).
- Wait condition (MW): Mem_req_i & !Mem_ready_i.
- Stall outputs: PC_Write_o=0, IF_ID_Write_o=0, ID_EX_Flush_o=1.
- Freeze outputs: PC_Write_o=0, IF_ID_Write_o=0, Pipe_Stall_o=1, all flushes 0.
- Flush outputs: IF_ID_Flush_o=ID_EX_Flush_o=EX_MEM_Flush_o=1, PC_Write_o=1, IF_ID_Write_o=1.
- Default outputs (no event): PC_Write_o=1, IF_ID_Write_o=1, all flushes 0, Pipe_Stall_o=0.
- Priority in every state: MW > Branch_taken_i > LU.
- RUN:
  - MW: freeze; return=RUN; wait counter=1; go to MEM_WAIT.
  - Branch: flush; stay in RUN.
  - LU: stall. If LOAD_STALL_CYCLES==1, stay in RUN; else stall counter=LOAD_STALL_CYCLES-1 and go to LOAD_STALL.
- LOAD_STALL: stall outputs every cycle regardless of LU.
  - Counter decrements; when it reads 1 at the edge, go to RUN.
  - Branch: flush, clear counter, go to RUN.
  - MW: freeze; return=LOAD_STALL; counter held; go to MEM_WAIT.
- MEM_WAIT: freeze outputs while Mem_ready_i=0.
  - Wait counter saturates at 255. Mem_timeout_o sets when counter==MEM_TIMEOUT and stays set until reset; the FSM keeps waiting.
  - Mem_ready_i=1: default outputs of the return state (LOAD_STALL → stall outputs). Next state = return state; wait counter=0.
  - Branch_taken_i is ignored in this state; the branch re-presents after the freeze.

## Timing
- Detection to control: 0 cycles (combinational). State change: 1 edge.
- Load-use: exactly LOAD_STALL_CYCLES cycles with PC_Write_o=0.
- Branch flush: 1 cycle.
- Freeze: lasts until the cycle Mem_ready_i=1, inclusive of the first-cycle decision.
- While rst_i=1: PC_Write_o=0, IF_ID_Write_o=0, all three flushes=1, Pipe_Stall_o=0.
- After the reset edge: State_o=0, counters=0, Mem_timeout_o=0.
- Reset mid-stall or mid-wait abandons the operation immediately.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds outputs Stall_cnt_o, Flush_cnt_o, Wait_cnt_o (32 bits each, saturating at 0xFFFFFFFF, cleared by rst_i). They count stall-output cycles, flush cycles and freeze cycles respectively.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- lw $2 in EX, ID reads Rs=2, LOAD_STALL_CYCLES=2 → PC_Write_o=0 and ID_EX_Flush_o=1 for 2 cycles, State_o 0→1→0.
- ID_EX_RegisterRt_i=0 with MemRead, ID Rs=0 → no stall.
- Branch_taken_i and LU in the same cycle → all three flushes=1, PC_Write_o=1, State_o stays 0.
- Mem_req_i=1, Mem_ready_i low 3 cycles then high → Pipe_Stall_o=1 for 3 cycles, then release.
- Repeat the wait entered from LOAD_STALL with counter 2 → FSM returns to LOAD_STALL and completes the remaining stall.
- MEM_TIMEOUT=4, Mem_ready_i held low → Mem_timeout_o rises after the 4th wait cycle and holds until rst_i. Assert rst_i mid-wait → State_o=0 next cycle.
